// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } sup_state_e;

    // Width of a counter that must hold the largest of three terminal counts.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser; clears to 0 on synchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep the two stages as separate flops.
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, qualifies LOCK and gates the downstream system reset,
// all from the free-running reference clock.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int DROP_FILTER   = 4,
    parameter int MAX_RETRY     = 7,
    parameter int LOSS_W        = 8
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              pll_lock,
    input  logic              relock_req,
    output logic              pll_reset,
    output logic              sys_rst_n,
    output logic              ready,
    output logic              fail,
    output logic [2:0]        state,
    output logic [2:0]        retry_cnt,
    output logic [LOSS_W-1:0] loss_cnt
);

    localparam int TMR_W  = timer_width(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES);
    localparam int DROP_W = $clog2(DROP_FILTER + 1);

    localparam logic [TMR_W-1:0]  RST_LAST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [DROP_W-1:0] DROP_LAST   = DROP_W'(DROP_FILTER - 1);
    localparam logic [2:0]        RETRY_MAX   = 3'(MAX_RETRY);

    sup_state_e        state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [2:0]        retry_q, retry_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic              pll_reset_q, sys_rst_n_q, ready_q, fail_q;
    logic              lock_s;

    sync_2ff u_lock_sync (
        .clk   (clkin),
        .rst_n (rst_n),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d = state_q;
        timer_d = timer_q;
        drop_d  = '0;
        retry_d = retry_q;
        loss_d  = loss_q;

        unique case (state_q)
            PLL_RST: begin
                if (timer_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    timer_d = '0;
                end else if (timer_q == LOCK_LAST) begin
                    timer_d = '0;
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAIL;
                    end else begin
                        state_d = PLL_RST;
                        retry_d = retry_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            STABLE: begin
                // A lock drop here is not a timeout, so the retry count is untouched.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = RUN;
                    timer_d = '0;
                    retry_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            RUN: begin
                if (!lock_s) begin
                    if (drop_q == DROP_LAST) begin
                        state_d = PLL_RST;
                        timer_d = '0;
                        if (loss_q != '1) loss_d = loss_q + 1'b1;
                    end else begin
                        drop_d = drop_q + 1'b1;
                    end
                end
            end

            FAIL: begin
                state_d = FAIL;
            end

            default: begin
                state_d = PLL_RST;
                timer_d = '0;
            end
        endcase

        // A relock request overrides timeout and drop decisions made above.
        if (relock_req && (state_q inside {WAIT_LOCK, STABLE, RUN, FAIL})) begin
            state_d = PLL_RST;
            timer_d = '0;
            drop_d  = '0;
            retry_d = '0;
            loss_d  = loss_q;
        end
    end

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            timer_q     <= '0;
            drop_q      <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            drop_q      <= drop_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            // Outputs decode the next state so they change on the same edge as the state.
            pll_reset_q <= (state_d == PLL_RST) || (state_d == FAIL);
            sys_rst_n_q <= (state_d == RUN);
            ready_q     <= (state_d == RUN);
            fail_q      <= (state_d == FAIL);
        end
    end

    assign pll_reset = pll_reset_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign state     = state_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Controls the PLL's RESET input and monitors its LOCK output, from the free-running 50 MHz reference clock (never the PLL output).
- Pulses PLL reset and waits for lock with a timeout, then requires lock to stay stable before releasing the system reset to the PWM logic.
- Filters lock glitches and re-initialises the PLL on a sustained lock loss.
- Counts retries and losses for status readout.

Parameters:
- RST_CYCLES, 16: cycles pll_reset is held high per reset attempt (>=1).
- LOCK_TIMEOUT, 50000: cycles allowed in WAIT_LOCK before a retry (1 ms @ 50 MHz).
- STABLE_CYCLES, 1024: consecutive synced-lock-high cycles required before RUN.
- DROP_FILTER, 4: consecutive synced-lock-low cycles in RUN treated as lock loss; shorter lows are ignored.
- MAX_RETRY, 7: timeouts tolerated before FAIL.
- LOSS_W, 8: width of the lock-loss counter.

Ports:
- clkin, input, 1: reference clock, same net as the PLL clkin.
- rst_n, input, 1: synchronous, active-low reset.
- pll_lock, input, 1: PLL LOCK output; asynchronous to clkin, synchronised internally.
- relock_req, input, 1: single-cycle request to re-initialise the PLL.
- pll_reset, output, 1: drives PLL RESET; active high.
- sys_rst_n, output, 1: downstream reset, active low; consumers re-synchronise it.
- ready, output, 1: high only in RUN.
- fail, output, 1: high only in FAIL.
- state, output, 3: current FSM state encoding.
- retry_cnt, output, 3: timeouts since the last RUN entry or relock_req.
- loss_cnt, output, LOSS_W: lock losses detected in RUN; saturating.

Behaviour:
- Reset: rst_n low at a clkin edge causes the following.
  - state = PLL_RST, pll_reset = 1, sys_rst_n = 0, ready = 0, fail = 0.
  - retry_cnt = 0, loss_cnt = 0, all timers 0, synchroniser flops 0.
  - Reset mid-operation behaves identically, from any state.
- All outputs are registered.
- lock_s is pll_lock through a 2-FF synchroniser, so it lags pll_lock by 2 cycles.
- PLL_RST (0):
  - pll_reset = 1.
  - The timer counts RST_CYCLES cycles, then the FSM goes to WAIT_LOCK.
  - pll_reset is high for exactly RST_CYCLES cycles after rst_n deasserts.
  - relock_req is ignored here.
- WAIT_LOCK (1):
  - pll_reset = 0 and the timer counts.
  - lock_s = 1 moves to STABLE with the timer cleared.
  - If the timer reaches LOCK_TIMEOUT-1 without lock:
    - retry_cnt == MAX_RETRY goes to FAIL.
    - Otherwise retry_cnt increments and the FSM goes to PLL_RST.
- STABLE (2):
  - The timer counts while lock_s = 1.
  - lock_s = 0 returns to WAIT_LOCK with the timer cleared; this is not a retry.
  - STABLE_CYCLES consecutive high cycles go to RUN.
- RUN (3):
  - sys_rst_n = 1, ready = 1, retry_cnt cleared on entry.
  - A drop counter increments while lock_s = 0 and clears when lock_s = 1.
  - When it reaches DROP_FILTER the FSM goes to PLL_RST, sys_rst_n = 0 in the same cycle, and loss_cnt increments.
  - loss_cnt saturates at all-ones.
- FAIL (4):
  - pll_reset = 1, sys_rst_n = 0, fail = 1.
  - Leaves only on relock_req (to PLL_RST, retry_cnt cleared) or on rst_n.
- relock_req in WAIT_LOCK, STABLE, RUN or FAIL:
  - Next state is PLL_RST; retry_cnt is cleared.
  - It has priority over timeout and drop events in the same cycle. Loss and retry counters do not increment in that cycle.
- sys_rst_n is 0 in every state except RUN, and it falls in the cycle the FSM leaves RUN.
- Timer width is $clog2(max(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES)+1), and the timer never wraps.
- Encodings 5–7 are illegal and recover to PLL_RST on the next cycle.

Decomposition:
- Package pll_sup_pkg holds:
  - the state enum: PLL_RST = 3'd0, WAIT_LOCK = 3'd1, STABLE = 3'd2, RUN = 3'd3, FAIL = 3'd4;
  - a width helper function for the timer.
- One sub-module: sync_2ff, a generic 1-bit two-flop synchroniser with synchronous active-low reset to 0. It is reused for other asynchronous inputs in the design.

Test Plan:
Bench parameters for all scenarios: RST_CYCLES = 4, LOCK_TIMEOUT = 20, STABLE_CYCLES = 8, DROP_FILTER = 3, MAX_RETRY = 2.
1. Nominal lock: release rst_n, raise pll_lock 6 cycles after pll_reset falls → pll_reset high for 4 cycles, RUN reached, sys_rst_n = 1 and ready = 1, retry_cnt = 0.
2. Glitch: in RUN, drive pll_lock low for 2 cycles → stays in RUN, loss_cnt = 0. Drive it low for 3 cycles → PLL_RST, sys_rst_n = 0, loss_cnt = 1, pll_reset high for 4 cycles.
3. Unstable lock: pll_lock high for 5 cycles, then low, in STABLE → returns to WAIT_LOCK, retry_cnt unchanged, ready never asserted.
4. No lock: hold pll_lock = 0 → 2 timeout retries (retry_cnt = 1, then 2), then the third timeout goes to FAIL with fail = 1 and pll_reset = 1. relock_req then gives PLL_RST with retry_cnt = 0.
5. Collision: relock_req in the same cycle as the third low cycle in RUN → PLL_RST, loss_cnt unchanged.
6. Reset mid-STABLE: assert rst_n low for one cycle → all outputs at reset values next cycle, loss_cnt = 0.
